tx_uart: RTL

- Serial UART transmitter for the lab UART link; the transmit-side counterpart of the team's `rx_uart` receiver.
- Takes a parallel WL-bit word via a start/busy handshake.
- Emits one frame per word: start bit (0), WL data bits LSB first, even-parity bit, stop bit (1).
- Sits between the user/control logic and the FPGA TX pin.

---
 rtl/tx_uart.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tx_uart.sv
// UART transmitter: start bit, WL data bits LSB first, even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module tx_uart #(
  parameter int unsigned WL        = 8,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 100000000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          tx_start,
  input  logic [WL-1:0] din,
  output logic          uart_tx,
  output logic          busy,
  output logic          tx_done
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BitW       = $clog2(WL + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(WL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [WL-1:0]   shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            uart_tx_q, uart_tx_d;
  logic            busy_q, busy_d;
  logic            tx_done_q, tx_done_d;
  logic            bit_end;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_done_d = 1'b0;
    bit_end   = (clk_cnt_q == CntMax);

    if (state_q != StIdle) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (tx_start) begin
          state_d   = StStart;
          shreg_d   = din;
          parity_d  = ^din;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BitMax) begin
            bit_cnt_d = '0;
            state_d   = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
`ifdef UART_TX_TWO_STOP_EN
        // bit_cnt is idle in STOP, so reuse it to count the two stop bits
        if (bit_end) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = '0;
            state_d   = StIdle;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = BitW'(1);
          end
        end
`else
        if (bit_end) begin
          state_d   = StIdle;
          tx_done_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Line level is decoded from the next state so the pin itself is a flop
    uart_tx_d = 1'b1;
    case (state_d)
      StIdle:   uart_tx_d = 1'b1;
      StStart:  uart_tx_d = 1'b0;
      StData:   uart_tx_d = shreg_d[0];
      StParity: uart_tx_d = parity_d;
      StStop:   uart_tx_d = 1'b1;
      default:  uart_tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      uart_tx_q <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      uart_tx_q <= uart_tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
